// File: rtl/dnn_stream_pkg.sv
// Shared types and defaults for the DNN input stream source: FSM states,
// lane count, counter width and the 4-word beat type.
package dnn_stream_pkg;
  localparam int DW_DEF    = 32;
  localparam int DEPTH_DEF = 4;
  localparam int NUM_LANES = 4;
  localparam int CNT_W     = 12;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [NUM_LANES-1:0][DW_DEF-1:0] beat_t;
endpackage

// File: rtl/dnn_beat_fifo.sv
// DEPTH-entry beat FIFO, first-word-fall-through head; a push on a full FIFO
// is taken when a pop happens in the same cycle.
module dnn_beat_fifo
  import dnn_stream_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [NUM_LANES-1:0][DW-1:0]   push_beat,
  input  logic                           pop,
  output logic [NUM_LANES-1:0][DW-1:0]   head,
  output logic                           full,
  output logic                           empty
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_LANES-1:0][DW-1:0] mem [DEPTH];
  logic [AW:0]                  wr_ptr, rd_ptr;
  logic                         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage is reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_beat;
        wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end
endmodule

// File: rtl/dnn_stream_src.sv
// Host word stream to 4-word beat stream: gathers words into lanes, queues
// beats in a small FIFO and tags the final beat of a len-beat transfer.
module dnn_stream_src
  import dnn_stream_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [11:0]      len,
  input  logic             wr_valid,
  input  logic [DW-1:0]    wr_data,
  output logic             wr_ready,
  output logic             src_valid,
  output logic [DW-1:0]    src_data0,
  output logic [DW-1:0]    src_data1,
  output logic [DW-1:0]    src_data2,
  output logic [DW-1:0]    src_data3,
  output logic             src_last,
  input  logic             src_ready,
  output logic             busy,
  output logic             done
);
  state_t                        state, state_nxt;
  logic [CNT_W-1:0]              len_q, push_cnt, pop_cnt;
  logic [1:0]                    word_cnt;
  logic [NUM_LANES-2:0][DW-1:0]  lane_q;
  logic [NUM_LANES-1:0][DW-1:0]  push_beat, head;
  logic                          fifo_full, fifo_empty;
  logic                          start_acc, wr_fire, push, pop, last_pop;
  logic                          done_q, done_nxt;

  assign start_acc = (state == IDLE) && start && (len != '0);
  assign wr_ready  = (state == RUN) && (push_cnt < len_q) &&
                     !(fifo_full && (word_cnt == 2'd3));
  assign wr_fire   = wr_valid && wr_ready;
  assign push      = wr_fire && (word_cnt == 2'd3);
  assign src_valid = !fifo_empty;
  assign pop       = src_valid && src_ready;
  assign src_last  = src_valid && (pop_cnt == len_q - 12'd1);
  assign last_pop  = pop && src_last;
  assign busy      = (state == RUN);
  assign done      = done_q;

  assign src_data0 = head[0];
  assign src_data1 = head[1];
  assign src_data2 = head[2];
  assign src_data3 = head[3];

  // The 4th word goes straight into the beat; only lanes 0..2 are registered.
  always_comb begin
    push_beat                = '0;
    push_beat[NUM_LANES-1]   = wr_data;
    for (int i = 0; i < NUM_LANES-1; i++) push_beat[i] = lane_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_LANES-1; i++)
        if (word_cnt == 2'(i)) lane_q[i] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      push_cnt <= '0;
      pop_cnt  <= '0;
      word_cnt <= '0;
    end else if (start_acc) begin
      len_q    <= len;
      push_cnt <= '0;
      pop_cnt  <= '0;
      word_cnt <= '0;
    end else if (state == RUN) begin
      if (wr_fire) word_cnt <= word_cnt + 2'd1;
      if (push)    push_cnt <= push_cnt + 12'd1;
      if (pop)     pop_cnt  <= pop_cnt + 12'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start_acc)  state_nxt = RUN;
        else if (start) done_nxt  = 1'b1;
      end
      RUN: begin
        if (last_pop) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  dnn_beat_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );
endmodule

// File: doc/dnn_stream_src.md
DNN_STREAM_SRC -- requirements
Module: dnn_stream_src

Interface
REQ-001 Parameter DW, default 32: width of one data word (IEEE-754 single bit pattern).
REQ-002 Parameter DEPTH, default 4: beat FIFO depth, power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a transfer; accepted only in IDLE.
REQ-006 len  input  12  transfer length in 4-word beats; sampled when start is accepted.
REQ-007 wr_valid  input  1  host word valid.
REQ-008 wr_data  input  DW  host word.
REQ-009 wr_ready  output  1  block accepts wr_data this cycle.
REQ-010 src_valid  output  1  beat valid toward the accelerator.
REQ-011 src_data0..src_data3  output  DW each  beat words; word 0 is the first received.
REQ-012 src_last  output  1  marks the final beat of the transfer.
REQ-013 src_ready  input  1  accelerator accepts the beat.
REQ-014 busy  output  1  high from accepted start until done.
REQ-015 done  output  1  one-cycle pulse when the final beat has been accepted.

Function
REQ-016 The FSM SHALL have states IDLE and RUN; reset state IDLE.
REQ-017 IDLE with start=1 and len!=0 SHALL latch len, clear word, beat-push and beat-pop counters, and go to RUN next cycle.
REQ-018 IDLE with start=1 and len=0 SHALL pulse done the next cycle and stay IDLE.
REQ-019 start in RUN SHALL be ignored, including in the cycle of the final pop.
REQ-020 A word is accepted when wr_valid and wr_ready; wr_ready = RUN and push_cnt < len and not (FIFO full and word_cnt = 3).
REQ-021 Accepted words fill lanes 0..3 in order (2-bit word_cnt, wraps 3->0); the 4th word SHALL push the assembled beat and increment push_cnt.
REQ-022 Latency: beat visible on src_valid/src_data the cycle after its 4th word is accepted.
REQ-023 src_valid = FIFO not empty; src_data0..3 = FIFO head; a beat pops on src_valid and src_ready.
REQ-024 src_data and src_last SHALL hold stable while src_valid=1 and src_ready=0.
REQ-025 src_last = src_valid and (pop_cnt = latched len - 1).
REQ-026 Simultaneous push and pop on a full FIFO SHALL be allowed and keep occupancy unchanged.
REQ-027 Pop of the src_last beat SHALL return the FSM to IDLE and pulse done the next cycle; busy falls with it.
REQ-028 After push_cnt reaches len, wr_ready SHALL remain 0 until the next transfer.
REQ-029 Counters are 12 bits; len=4095 SHALL complete without wrap.

Reset
REQ-030 rst SHALL asynchronously force IDLE, clear counters and FIFO pointers; wr_ready, src_valid, src_last, busy, done = 0; src_data0..3 = 0.
REQ-031 rst during RUN SHALL discard partial and queued beats; no done pulse results.

Structure
REQ-032 Package dnn_stream_pkg SHALL hold DW and DEPTH defaults, the state enum (IDLE, RUN) and the beat type (4 x DW).
REQ-033 Sub-module dnn_beat_fifo SHALL implement the DEPTH-entry beat FIFO with full/empty flags and first-word-fall-through head.

Verification
REQ-034 len=1, words 1..4 back-to-back, src_ready=1 -> one beat data0..3=1,2,3,4, src_last=1, done pulse 1 cycle after pop.
REQ-035 len=3, src_ready=0 for 20 cycles -> 3 beats buffered; wr_ready drops after 12th word; release gives 3 in-order beats, last only on the 3rd.
REQ-036 len=6, src_ready toggling every cycle, wr_valid random -> 24 words delivered in order, src_data stable while stalled.
REQ-037 len=0 start -> done pulse next cycle, busy never high, no src_valid.
REQ-038 len=4, rst asserted after 7 words -> all outputs 0 immediately; a following len=1 transfer completes correctly.
REQ-039 start pulsed in the final-pop cycle of a len=2 transfer -> start ignored, block idle afterwards.
